// File: rtl/spi_rsp_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : spi_rsp_uart_tx
//  Purpose  : Captures MISO bytes from one SPI chip-select window and returns
//             them to the host as an 8N1 UART frame:
//             header, count, data bytes, checksum.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_rsp_uart_tx #(
   parameter int         DVSR      = 22,
   parameter int         MAX_BYTES = 4,
   parameter logic [7:0] HDR       = 8'hB1
) (
   input  logic       clk40M,
   input  logic       nRst,
   input  logic       spi_rx_dv,
   input  logic [7:0] spi_rx_byte,
   input  logic       spi_cs_n,
   input  logic       ovf_clr,
   output logic       uart_tx,
   output logic       busy,
   output logic       overflow
);

   localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
   localparam int CNT_W = $clog2(MAX_BYTES + 1);

   // One UART bit lasts 16*DVSR clocks; counter wraps at the last clock
   localparam logic [15:0]      BIT_LAST = 16'(16 * DVSR - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_BYTES);

   localparam logic [2:0] SEQ_IDLE = 3'd0;
   localparam logic [2:0] SEQ_HDR  = 3'd1;
   localparam logic [2:0] SEQ_CNT  = 3'd2;
   localparam logic [2:0] SEQ_DATA = 3'd3;
   localparam logic [2:0] SEQ_SUM  = 3'd4;

   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   logic [2:0]       seq_state, seq_next;
   logic [1:0]       tx_state, tx_next;
   logic [15:0]      bit_cnt, bit_cnt_next;
   logic [2:0]       bit_idx, bit_idx_next;
   logic [IDX_W-1:0] data_idx, data_idx_next;
   logic [7:0]       shreg, shreg_next;
   logic [CNT_W-1:0] count, count_cap, count_next;
   logic [7:0]       sum, sum_next;
   logic [7:0]       cap_buf [MAX_BYTES];
   logic             cs_cur, cs_prev;
   logic             busy_next, overflow_next, tx_line_next;
   logic             accept, drop, cs_rise, start_frame;
   logic             bit_end, byte_end, frame_done;
   logic [7:0]       load_byte;

   // Capture decisions, window-end detection and sticky flag updates
   always_comb begin
      cs_rise     = cs_cur & ~cs_prev;
      accept      = spi_rx_dv & ~busy & (count != CNT_FULL);
      drop        = spi_rx_dv & ~accept;
      count_cap   = count + CNT_W'(accept);
      // A byte captured in the rise cycle already counts toward the frame
      start_frame = cs_rise & ~busy & (count_cap != '0);
      bit_end     = (bit_cnt == BIT_LAST);
      byte_end    = (tx_state == TX_STOP) & bit_end;
      frame_done  = byte_end & (seq_state == SEQ_SUM);

      count_next = frame_done ? '0 : count_cap;
      sum_next   = sum;
      if (frame_done)
         sum_next = '0;
      else if (accept)
         sum_next = sum + spi_rx_byte;

      busy_next = busy;
      if (start_frame)
         busy_next = 1'b1;
      else if (frame_done)
         busy_next = 1'b0;

      // A drop in the same cycle as a clear keeps the flag set
      overflow_next = overflow;
      if (drop)
         overflow_next = 1'b1;
      else if (ovf_clr)
         overflow_next = 1'b0;
   end

   // Next state of the frame sequencer and the bit serializer
   always_comb begin
      seq_next      = seq_state;
      data_idx_next = data_idx;
      case (seq_state)
         SEQ_IDLE: if (start_frame) begin
            seq_next      = SEQ_HDR;
            data_idx_next = '0;
         end
         SEQ_HDR:  if (byte_end) seq_next = SEQ_CNT;
         SEQ_CNT:  if (byte_end) begin
            seq_next      = SEQ_DATA;
            data_idx_next = '0;
         end
         SEQ_DATA: if (byte_end) begin
            if (CNT_W'(data_idx) + CNT_W'(1) == count)
               seq_next = SEQ_SUM;
            else
               data_idx_next = data_idx + IDX_W'(1);
         end
         SEQ_SUM:  if (byte_end) seq_next = SEQ_IDLE;
         default:  seq_next = SEQ_IDLE;
      endcase

      // Byte that the serializer picks up when it enters a start bit
      case (seq_next)
         SEQ_HDR:  load_byte = HDR;
         SEQ_CNT:  load_byte = 8'(count);
         SEQ_DATA: load_byte = cap_buf[data_idx_next];
         SEQ_SUM:  load_byte = 8'(count) + sum;
         default:  load_byte = 8'hFF;
      endcase

      tx_next      = tx_state;
      bit_cnt_next = bit_end ? 16'd0 : bit_cnt + 16'd1;
      bit_idx_next = bit_idx;
      shreg_next   = shreg;
      case (tx_state)
         TX_IDLE: begin
            bit_cnt_next = 16'd0;
            if (start_frame) begin
               tx_next    = TX_START;
               shreg_next = load_byte;
            end
         end
         TX_START: if (bit_end) begin
            tx_next      = TX_DATA;
            bit_idx_next = 3'd0;
         end
         TX_DATA: if (bit_end) begin
            shreg_next = {1'b1, shreg[7:1]};
            if (bit_idx == 3'd7)
               tx_next = TX_STOP;
            else
               bit_idx_next = bit_idx + 3'd1;
         end
         TX_STOP: if (bit_end) begin
            // Next start bit follows the stop bit with no idle gap
            if (seq_state == SEQ_SUM) begin
               tx_next = TX_IDLE;
            end else begin
               tx_next    = TX_START;
               shreg_next = load_byte;
            end
         end
         default: tx_next = TX_IDLE;
      endcase
   end

   // Line level for the coming cycle, registered so uart_tx is glitch-free
   always_comb begin
      tx_line_next = 1'b1;
      case (tx_next)
         TX_START: tx_line_next = 1'b0;
         TX_DATA:  tx_line_next = shreg_next[0];
         default:  tx_line_next = 1'b1;
      endcase
   end

   // State, counters, flags and serial line registers
   always_ff @(posedge clk40M or negedge nRst) begin
      if (!nRst) begin
         seq_state <= SEQ_IDLE;
         tx_state  <= TX_IDLE;
         bit_cnt   <= 16'd0;
         bit_idx   <= 3'd0;
         data_idx  <= '0;
         shreg     <= 8'hFF;
         count     <= '0;
         sum       <= 8'd0;
         cs_cur    <= 1'b1;
         cs_prev   <= 1'b1;
         busy      <= 1'b0;
         overflow  <= 1'b0;
         uart_tx   <= 1'b1;
      end else begin
         seq_state <= seq_next;
         tx_state  <= tx_next;
         bit_cnt   <= bit_cnt_next;
         bit_idx   <= bit_idx_next;
         data_idx  <= data_idx_next;
         shreg     <= shreg_next;
         count     <= count_next;
         sum       <= sum_next;
         cs_cur    <= spi_cs_n;
         cs_prev   <= cs_cur;
         busy      <= busy_next;
         overflow  <= overflow_next;
         uart_tx   <= tx_line_next;
      end
   end

   // Capture buffer write port, indexed by the current byte count
   always_ff @(posedge clk40M or negedge nRst) begin
      if (!nRst) begin
         for (int i = 0; i < MAX_BYTES; i++)
            cap_buf[i] <= 8'd0;
      end else if (accept) begin
         cap_buf[count[IDX_W-1:0]] <= spi_rx_byte;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_rsp_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spi_rsp_uart_tx
//  Purpose  : Randomized and directed bench for spi_rsp_uart_tx with a
//             frame-level reference model and a UART line decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_rsp_uart_tx;

   localparam int         DVSR      = 4;
   localparam int         MAX_BYTES = 4;
   localparam logic [7:0] HDR       = 8'hB1;
   localparam int         BIT       = 16 * DVSR;
   localparam int         BYTE_CLKS = 10 * BIT;

   logic       clk40M      = 1'b0;
   logic       nRst        = 1'b0;
   logic       spi_rx_dv   = 1'b0;
   logic [7:0] spi_rx_byte = 8'd0;
   logic       spi_cs_n    = 1'b1;
   logic       ovf_clr     = 1'b0;
   logic       uart_tx, busy, overflow;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int framing_err = 0;

   byte unsigned rx_q[$];
   byte unsigned exp_q[$];
   byte unsigned win_q[$];
   bit  model_ovf  = 1'b0;
   int  busy_start = -1;
   int  busy_end   = -1;

   spi_rsp_uart_tx #(.DVSR(DVSR), .MAX_BYTES(MAX_BYTES), .HDR(HDR)) dut (
      .clk40M      (clk40M),
      .nRst        (nRst),
      .spi_rx_dv   (spi_rx_dv),
      .spi_rx_byte (spi_rx_byte),
      .spi_cs_n    (spi_cs_n),
      .ovf_clr     (ovf_clr),
      .uart_tx     (uart_tx),
      .busy        (busy),
      .overflow    (overflow)
   );

   always #5 clk40M = ~clk40M;

   // Free-running edge count used by the timing model
   always @(posedge clk40M) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   function automatic bit model_busy(input int c);
      return (c >= busy_start) && (c < busy_end);
   endfunction

   // Returns 1 when the byte is dropped
   function automatic bit model_dv(input logic [7:0] b);
      if (!model_busy(cyc) && win_q.size() < MAX_BYTES) begin
         win_q.push_back(b);
         return 1'b0;
      end
      return 1'b1;
   endfunction

   // Drives one clock of dv/clear starting at a falling edge
   task automatic drive_cycle(input bit dv, input logic [7:0] b, input bit clr);
      bit set_now;
      set_now     = 1'b0;
      spi_rx_dv   = dv;
      spi_rx_byte = b;
      ovf_clr     = clr;
      if (dv) set_now = model_dv(b);
      if (set_now)  model_ovf = 1'b1;
      else if (clr) model_ovf = 1'b0;
      @(negedge clk40M);
      spi_rx_dv = 1'b0;
      ovf_clr   = 1'b0;
   endtask

   // Raises cs_n; optionally sends a byte in the rise-detection cycle
   task automatic end_window(input bit same_dv, input logic [7:0] b, output bit framed);
      int k;
      int s;
      bit set_now;
      spi_cs_n = 1'b1;
      k = cyc;
      @(negedge clk40M);
      if (same_dv) begin
         spi_rx_dv   = 1'b1;
         spi_rx_byte = b;
         set_now = model_dv(b);
         if (set_now) model_ovf = 1'b1;
      end
      framed = 1'b0;
      if (!model_busy(k + 1) && win_q.size() > 0) begin
         exp_q.delete();
         exp_q.push_back(HDR);
         exp_q.push_back(8'(win_q.size()));
         s = win_q.size();
         foreach (win_q[i]) begin
            exp_q.push_back(win_q[i]);
            s += win_q[i];
         end
         exp_q.push_back(8'(s % 256));
         busy_start = k + 2;
         busy_end   = k + 2 + BYTE_CLKS * (win_q.size() + 3);
         win_q.delete();
         rx_q.delete();
         framing_err = 0;
         framed = 1'b1;
         check("pre_start_tx", uart_tx, 1);
         check("pre_start_busy", busy, 0);
      end
      @(negedge clk40M);
      spi_rx_dv = 1'b0;
      if (framed) begin
         check("start_busy", busy, 1);
         check("start_bit", uart_tx, 0);
      end
   endtask

   // Waits for the modelled frame end, checks busy edges and decoded bytes
   task automatic finish_frame(input string tag);
      while (cyc < busy_end - 1) @(negedge clk40M);
      check({tag, "_busy_last"}, busy, 1);
      @(negedge clk40M);
      check({tag, "_busy_fall"}, busy, 0);
      check({tag, "_framing"}, framing_err, 0);
      check({tag, "_len"}, rx_q.size(), exp_q.size());
      foreach (exp_q[i])
         check($sformatf("%s_b%0d", tag, i),
               (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF, exp_q[i]);
   endtask

   // UART line decoder: mid-bit sampling, 8N1, LSB first
   initial begin : rx_mon
      logic [7:0] sh;
      forever begin
         @(negedge clk40M);
         if (nRst === 1'b1 && uart_tx === 1'b0) begin
            repeat (BIT / 2 - 1) @(negedge clk40M);
            if (uart_tx === 1'b0) begin
               for (int i = 0; i < 8; i++) begin
                  repeat (BIT) @(negedge clk40M);
                  sh[i] = uart_tx;
               end
               repeat (BIT) @(negedge clk40M);
               if (uart_tx !== 1'b1) framing_err++;
               rx_q.push_back(sh);
            end
         end
      end
   end

   initial begin : watchdog
      #3_000_000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "timeout");
   end

   initial begin : main
      bit f;
      int bad_tx, bad_busy, nb, target;
      bit same;
      logic [7:0] b;
      logic [7:0] base [4];
      base[0] = 8'h12; base[1] = 8'h34; base[2] = 8'h56; base[3] = 8'h78;

      repeat (3) @(negedge clk40M);
      check("rst_tx", uart_tx, 1);
      check("rst_busy", busy, 0);
      check("rst_ovf", overflow, 0);
      nRst = 1'b1;
      repeat (3) @(negedge clk40M);

      // Baseline four-byte window
      spi_cs_n = 1'b0;
      @(negedge clk40M);
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, base[i], 1'b0);
      @(negedge clk40M);
      end_window(1'b0, 8'h00, f);
      finish_frame("base");
      check("base_ovf", overflow, model_ovf);

      // Byte arriving in the rise-detection cycle
      spi_cs_n = 1'b0;
      repeat (2) @(negedge clk40M);
      end_window(1'b1, 8'hA5, f);
      finish_frame("same");

      // Empty window sends nothing
      spi_cs_n = 1'b0;
      repeat (2) @(negedge clk40M);
      end_window(1'b0, 8'h00, f);
      bad_tx = 0;
      bad_busy = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk40M);
         if (uart_tx !== 1'b1) bad_tx++;
         if (busy !== 1'b0) bad_busy++;
      end
      check("empty_tx_high", bad_tx, 0);
      check("empty_busy_low", bad_busy, 0);

      // Five bytes into a four-byte buffer, then a dv while busy
      spi_cs_n = 1'b0;
      @(negedge clk40M);
      for (int i = 1; i <= 5; i++) drive_cycle(1'b1, 8'(i), 1'b0);
      check("ovf_set", overflow, model_ovf);
      end_window(1'b0, 8'h00, f);
      repeat (1000) @(negedge clk40M);
      drive_cycle(1'b1, 8'hEE, 1'b0);
      check("ovf_busy_drop", overflow, model_ovf);
      finish_frame("ovf");
      drive_cycle(1'b0, 8'h00, 1'b1);
      check("ovf_clr", overflow, model_ovf);

      // Reset in the middle of the first data byte
      spi_cs_n = 1'b0;
      @(negedge clk40M);
      drive_cycle(1'b1, 8'h00, 1'b0);
      drive_cycle(1'b1, 8'h00, 1'b0);
      drive_cycle(1'b1, 8'h3C, 1'b0);
      end_window(1'b0, 8'h00, f);
      target = busy_start + 2 * BYTE_CLKS + 3 * BIT + 10;
      while (cyc < target) @(negedge clk40M);
      check("rst_mid_low", uart_tx, 0);
      #2 nRst = 1'b0;
      #1;
      check("rst_mid_tx", uart_tx, 1);
      check("rst_mid_busy", busy, 0);
      win_q.delete();
      model_ovf  = 1'b0;
      busy_start = -1;
      busy_end   = -1;
      repeat (3) @(negedge clk40M);
      nRst = 1'b1;
      repeat (BYTE_CLKS + 10) @(negedge clk40M);
      rx_q.delete();
      framing_err = 0;
      spi_cs_n = 1'b0;
      @(negedge clk40M);
      drive_cycle(1'b1, 8'h7F, 1'b0);
      end_window(1'b0, 8'h00, f);
      finish_frame("post_rst");

      // Second window while the first frame is sending, then a third
      spi_cs_n = 1'b0;
      @(negedge clk40M);
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'($urandom), 1'b0);
      end_window(1'b0, 8'h00, f);
      repeat (200) @(negedge clk40M);
      spi_cs_n = 1'b0;
      @(negedge clk40M);
      drive_cycle(1'b1, 8'($urandom), 1'b0);
      drive_cycle(1'b1, 8'($urandom), 1'b1);
      end_window(1'b0, 8'h00, f);
      check("b2b_ovf", overflow, model_ovf);
      finish_frame("b2b_first");
      spi_cs_n = 1'b0;
      @(negedge clk40M);
      for (int i = 0; i < 2; i++) drive_cycle(1'b1, 8'($urandom), 1'b0);
      end_window(1'b0, 8'h00, f);
      finish_frame("b2b_third");

      // Randomized windows
      for (int r = 0; r < 6; r++) begin
         if ($urandom_range(0, 1) == 1) drive_cycle(1'b0, 8'h00, 1'b1);
         nb   = $urandom_range(0, 6);
         same = ($urandom_range(0, 2) == 0);
         spi_cs_n = 1'b0;
         @(negedge clk40M);
         for (int j = 0; j < nb; j++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk40M);
            drive_cycle(1'b1, 8'($urandom), 1'b0);
         end
         b = 8'($urandom);
         end_window(same, b, f);
         if (f) begin
            finish_frame($sformatf("rnd%0d", r));
         end else begin
            repeat (100) @(negedge clk40M);
            check($sformatf("rnd%0d_idle_busy", r), busy, 0);
         end
         check($sformatf("rnd%0d_ovf", r), overflow, model_ovf);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
